// File: rtl/ks_adder_pipe_if.sv
// Operand/result handshake bundle for ks_adder_pipe.
// KSA_OVERFLOW_EN adds the signed-overflow flag ovf alongside sum.
interface ks_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef KSA_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
`ifdef KSA_OVERFLOW_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
`ifdef KSA_OVERFLOW_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract with stall-all valid/ready flow control.
// Optional signed-overflow output enabled by defining KSA_OVERFLOW_EN.
module ks_adder_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PIPE_EVERY = 2
) (
  input  logic           clk,
  input  logic           rst,
  ks_adder_pipe_if.slave bus
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned NSTG   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] pg;
    logic [WIDTH-1:0] p;
    logic             c;
`ifdef KSA_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif
  } stage_t;

  stage_t           in_stage;
  stage_t           st_q [NSTG];
  stage_t           grp  [NSTG];
  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;
  logic             cout_q;
  logic             cout_c;
`ifdef KSA_OVERFLOW_EN
  logic             ovf_q;
  logic             ovf_c;
`endif

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance && !rst;

  // Operand conditioning; carry-in is folded into bit 0 so the prefix tree yields carries directly.
  always_comb begin : input_stage
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    b_eff          = bus.sub ? ~bus.B : bus.B;
    c_eff          = bus.sub | bus.cin;
    in_stage       = '0;
    in_stage.v     = bus.in_valid;
    in_stage.p     = bus.A ^ b_eff;
    in_stage.g     = bus.A & b_eff;
    in_stage.g[0]  = in_stage.g[0] | (in_stage.p[0] & c_eff);
    in_stage.pg    = in_stage.p;
    in_stage.pg[0] = 1'b0;
    in_stage.c     = c_eff;
`ifdef KSA_OVERFLOW_EN
    in_stage.a_msb = bus.A[WIDTH-1];
    in_stage.b_msb = b_eff[WIDTH-1];
`endif
  end

  // Each register group applies up to PIPE_EVERY prefix levels of span 2^k.
  always_comb begin : prefix
    logic [WIDTH-1:0] g, pg, gn, pn;
    int unsigned      span;
    g    = '0;
    pg   = '0;
    gn   = '0;
    pn   = '0;
    span = 0;
    for (int unsigned j = 0; j < NSTG; j++) begin
      g  = st_q[j].g;
      pg = st_q[j].pg;
      for (int unsigned k = j * PIPE_EVERY; k < (j + 1) * PIPE_EVERY; k++) begin
        if (k < LEVELS) begin
          span = 32'd1 << k;
          gn   = g;
          pn   = pg;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i >= span) begin
              gn[i] = g[i] | (pg[i] & g[i-span]);
              pn[i] = pg[i] & pg[i-span];
            end
          end
          g  = gn;
          pg = pn;
        end
      end
      grp[j]    = st_q[j];
      grp[j].g  = g;
      grp[j].pg = pg;
    end
  end

  always_comb begin : result
    carry_c = {grp[NSTG-1].g[WIDTH-2:0], grp[NSTG-1].c};
    sum_c   = grp[NSTG-1].p ^ carry_c;
    cout_c  = grp[NSTG-1].g[WIDTH-1];
`ifdef KSA_OVERFLOW_EN
    ovf_c   = (grp[NSTG-1].a_msb == grp[NSTG-1].b_msb) && (sum_c[WIDTH-1] != grp[NSTG-1].a_msb);
`endif
  end

  // Whole pipe advances together; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < NSTG; j++) st_q[j].v <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef KSA_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else if (advance) begin
      st_q[0] <= in_stage;
      for (int unsigned j = 1; j < NSTG; j++) st_q[j] <= grp[j-1];
      out_valid_q <= grp[NSTG-1].v;
      sum_q       <= sum_c;
      cout_q      <= cout_c;
`ifdef KSA_OVERFLOW_EN
      ovf_q       <= ovf_c;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef KSA_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: directed beats, throughput, stall, reset flush.
module tb_ks_adder_pipe;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ks_adder_pipe_if #(.WIDTH(W)) bus ();
  ks_adder_pipe #(.WIDTH(W), .PIPE_EVERY(2)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef KSA_OVERFLOW_EN
  ks_adder_pipe_if #(.WIDTH(8)) bus8 ();
  ks_adder_pipe #(.WIDTH(8), .PIPE_EVERY(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_out = 0;
  int   run   = 0;
  int   acc_cyc = 0;
  int   out_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    logic [15:0] be;
    logic [16:0] r;
    exp_t        e;
    be     = s ? ~b : b;
    r      = 17'(a) + 17'(be) + 17'(s ? 1'b1 : c);
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (a[15] == be[15]) && (r[15] != a[15]);
    return e;
  endfunction

  // Monitor: pops the oldest expectation for every output handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got sum %0h with nothing outstanding, required no output", bus.sum);
        end else begin
          e = sb.pop_front();
          check("sum", 32'(bus.sum), 32'(e.sum));
          check("cout", 32'(bus.cout), 32'(e.cout));
`ifdef KSA_OVERFLOW_EN
          check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        end
        run     = (cyc == out_cyc + 1) ? run + 1 : 1;
        out_cyc = cyc;
        n_out++;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s, input exp_t e);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.cin      = c;
    bus.sub      = s;
    #2;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (bus.in_ready === 1'b1) begin
      sb.push_back(e);
      acc_cyc = cyc;
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string name);
    int guard;
    guard = 0;
    while (n_out < n && guard < 200) begin
      @(negedge clk);
      #3;
      guard++;
    end
    check(name, 32'(n_out), 32'(n));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          base;
    int          acc_first;
    int          guard;
    logic [15:0] a, b, snap_sum;
    logic        snap_cout;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef KSA_OVERFLOW_EN
    bus8.in_valid  = 1'b0;
    bus8.A         = '0;
    bus8.B         = '0;
    bus8.cin       = 1'b0;
    bus8.sub       = 1'b0;
    bus8.out_ready = 1'b1;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Full carry ripple and first-result latency
    base = n_out;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    idle();
    wait_out(base + 1, "t1_count");
    check("t1_latency", 32'(out_cyc - acc_cyc), 32'd3);

    // Subtract both ways, cin ignored under sub, assorted adds
    base = n_out;
    send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'h0007, 16'h0005, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0));
    send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'h0007, 16'h0005, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0));
    send(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0));
    send(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1));
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    idle();
    wait_out(base + 8, "t2_count");

    // Back-to-back stream
    base      = n_out;
    acc_first = 0;
    for (int i = 0; i < 20; i++) begin
      a = 16'(i * 16'h1357 + 16'h0F0F);
      b = 16'(16'hF00D - i * 16'h0777);
      send(a, b, 1'(i % 2), 1'(i % 3 == 0), model(a, b, 1'(i % 2), 1'(i % 3 == 0)));
      if (i == 0) acc_first = acc_cyc;
    end
    idle();
    wait_out(base + 20, "t3_count");
    check("t3_accept_span", 32'(acc_cyc - acc_first), 32'd19);
    check("t3_consecutive", 32'(run), 32'd20);

    // Backpressure: 4-cycle stall after first out_valid
    base = n_out;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          a = 16'(16'h0101 * (i + 1));
          b = 16'(16'h3030 + i);
          send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
        end
        idle();
      end
      begin
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        check("t4_saw_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        #1;
        snap_sum  = bus.sum;
        snap_cout = bus.cout;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          #1;
          check("t4_stall_sum", 32'(bus.sum), 32'(snap_sum));
          check("t4_stall_cout", 32'(bus.cout), 32'(snap_cout));
          check("t4_stall_valid", 32'(bus.out_valid), 32'd1);
          check("t4_stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(base + 5, "t4_count");

    // Reset flush with two beats in flight
    base = n_out;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0));
    send(16'h3333, 16'h4444, 1'b0, 1'b0, mk(16'h7777, 1'b0, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    sb.delete();
    #1;
    check("t5_in_ready_in_rst", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_out_valid_after_rst", 32'(bus.out_valid), 32'd0);
    repeat (6) @(negedge clk);
    check("t5_no_flushed", 32'(n_out), 32'(base));
    send(16'h0101, 16'h0202, 1'b0, 1'b0, mk(16'h0303, 1'b0, 1'b0));
    idle();
    wait_out(base + 1, "t5_count");
    check("t5_latency", 32'(out_cyc - acc_cyc), 32'd3);

`ifdef KSA_OVERFLOW_EN
    // Narrow instance, three levels in one group
    @(negedge clk);
    bus8.A        = 8'h80;
    bus8.B        = 8'h01;
    bus8.cin      = 1'b0;
    bus8.sub      = 1'b1;
    bus8.in_valid = 1'b1;
    #2;
    check("t6_in_ready", 32'(bus8.in_ready), 32'd1);
    acc_first = cyc;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1;
    guard = 0;
    while (bus8.out_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("t6_latency", 32'(cyc - acc_first), 32'd2);
    check("t6_sum", 32'(bus8.sum), 32'h7F);
    check("t6_cout", 32'(bus8.cout), 32'd1);
    check("t6_ovf", 32'(bus8.ovf), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
